// File: rtl/plain_broadcast_sched.sv
// Sequencer for the broadcast loop. For each repetition it fetches the operands,
// starts the core, waits for the result and writes it back.
module plain_broadcast_sched #(
  parameter PARAMETER_SET = "L1",
  parameter int NITER = 17 * ((PARAMETER_SET == "L1") ? 1 : 2),
  parameter int AW = $clog2(NITER),
  localparam int T = (PARAMETER_SET == "L5") ? 4 : 3,
  localparam int W = T * 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_in_addr,
  output logic          o_in_rd,
  input  logic [W-1:0]  i_r,
  input  logic [W-1:0]  i_eps,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  output logic          o_core_start,
  output logic [W-1:0]  o_core_r,
  output logic [W-1:0]  o_core_eps,
  output logic [W-1:0]  o_core_a,
  output logic [W-1:0]  o_core_b,
  input  logic          i_core_done,
  input  logic [W-1:0]  i_alpha,
  input  logic [W-1:0]  i_beta,
  output logic [AW-1:0] o_out_addr,
  output logic          o_out_wr,
  output logic [W-1:0]  o_alpha,
  output logic [W-1:0]  o_beta
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, START, WAIT, WRITE, DONE} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NITER - 1);

  state_t          state_reg;
  logic [AW-1:0]   index_reg;
  logic            busy_reg, done_reg, in_rd_reg, core_start_reg, out_wr_reg;
  logic [AW-1:0]   in_addr_reg, out_addr_reg;
  logic [W-1:0]    core_r_reg, core_eps_reg, core_a_reg, core_b_reg;
  logic [W-1:0]    alpha_reg, beta_reg;

  // Strobes are registered on the transition into their state so each one
  // is high for exactly the cycle spent in that state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      index_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      in_rd_reg      <= 1'b0;
      core_start_reg <= 1'b0;
      out_wr_reg     <= 1'b0;
      in_addr_reg    <= '0;
      out_addr_reg   <= '0;
      core_r_reg     <= '0;
      core_eps_reg   <= '0;
      core_a_reg     <= '0;
      core_b_reg     <= '0;
      alpha_reg      <= '0;
      beta_reg       <= '0;
    end else begin
      in_rd_reg      <= 1'b0;
      core_start_reg <= 1'b0;
      out_wr_reg     <= 1'b0;
      done_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            state_reg   <= FETCH;
            index_reg   <= '0;
            busy_reg    <= 1'b1;
            in_rd_reg   <= 1'b1;
            in_addr_reg <= '0;
          end
        end
        FETCH: state_reg <= LATCH;
        LATCH: begin
          core_r_reg     <= i_r;
          core_eps_reg   <= i_eps;
          core_a_reg     <= i_a;
          core_b_reg     <= i_b;
          core_start_reg <= 1'b1;
          state_reg      <= START;
        end
        START: state_reg <= WAIT;
        WAIT: begin
          if (i_core_done) begin
            alpha_reg    <= i_alpha;
            beta_reg     <= i_beta;
            out_wr_reg   <= 1'b1;
            out_addr_reg <= index_reg;
            state_reg    <= WRITE;
          end
        end
        WRITE: begin
          if (index_reg == LAST_IDX) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            index_reg   <= index_reg + AW'(1);
            in_addr_reg <= index_reg + AW'(1);
            in_rd_reg   <= 1'b1;
            state_reg   <= FETCH;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = busy_reg;
  assign o_done       = done_reg;
  assign o_in_addr    = in_addr_reg;
  assign o_in_rd      = in_rd_reg;
  assign o_core_start = core_start_reg;
  assign o_core_r     = core_r_reg;
  assign o_core_eps   = core_eps_reg;
  assign o_core_a     = core_a_reg;
  assign o_core_b     = core_b_reg;
  assign o_out_addr   = out_addr_reg;
  assign o_out_wr     = out_wr_reg;
  assign o_alpha      = alpha_reg;
  assign o_beta       = beta_reg;

endmodule

// File: tb/tb_plain_broadcast_sched.sv
// Bench for plain_broadcast_sched: operand memories and a stub XOR core around an
// L1 and an L3 instance, with results checked against a per-index expected list.
module tb_plain_broadcast_sched;
  localparam int W  = 96;
  localparam int N1 = 17;
  localparam int N3 = 34;
  localparam logic [W-1:0] BASE = 96'h01ac0e4b72e51961d2bb6fe5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] mr [0:N3-1];
  logic [W-1:0] me [0:N3-1];
  logic [W-1:0] ma [0:N3-1];
  logic [W-1:0] mb [0:N3-1];

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction

  // ---------------- L1 instance ----------------
  logic         start1 = 1'b0, busy1, done1, in_rd1, core_start1, out_wr1, core_done1;
  logic [4:0]   in_addr1, out_addr1;
  logic [W-1:0] r1, eps1, a1, b1, cr1, ce1, ca1, cb1, alpha_in1, beta_in1, alpha1, beta1;
  logic         stub_done1 = 1'b0, spur1 = 1'b0, spur_en = 1'b0, pend1 = 1'b0;
  logic [4:0]   pa1;
  logic [W-1:0] sa1, sb1;
  int lc1 = 3, cnt1 = 0, done_cnt1 = 0, done_cyc1 = 0, strobe_cnt1 = 0, excl_viol1 = 0;
  int wa1[$];
  int wc1[$];
  logic [W-1:0] wal1[$];
  logic [W-1:0] wbe1[$];
  assign core_done1 = stub_done1 | spur1;

  plain_broadcast_sched #(.PARAMETER_SET("L1")) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_in_addr(in_addr1), .o_in_rd(in_rd1), .i_r(r1), .i_eps(eps1), .i_a(a1), .i_b(b1),
    .o_core_start(core_start1), .o_core_r(cr1), .o_core_eps(ce1), .o_core_a(ca1),
    .o_core_b(cb1), .i_core_done(core_done1), .i_alpha(alpha_in1), .i_beta(beta_in1),
    .o_out_addr(out_addr1), .o_out_wr(out_wr1), .o_alpha(alpha1), .o_beta(beta1));

  // Environment updates at the falling edge so everything is stable at the rising edge.
  always @(negedge clk) begin
    int ns;
    if (pend1) begin
      r1 = mr[pa1]; eps1 = me[pa1]; a1 = ma[pa1]; b1 = mb[pa1];
    end else begin
      r1 = rnd(); eps1 = rnd(); a1 = rnd(); b1 = rnd();
    end
    spur1 = spur_en && (in_rd1 || core_start1 || pend1);
    pend1 = in_rd1;
    pa1 = in_addr1;
    stub_done1 = 1'b0;
    if (cnt1 > 0) begin
      cnt1--;
      if (cnt1 == 0) stub_done1 = 1'b1;
    end
    if (core_start1) begin
      cnt1 = lc1; sa1 = cr1 ^ ce1; sb1 = ca1 ^ cb1;
    end
    alpha_in1 = stub_done1 ? sa1 : rnd();
    beta_in1  = stub_done1 ? sb1 : rnd();
    if (out_wr1) begin
      wa1.push_back(int'(out_addr1)); wc1.push_back(cyc);
      wal1.push_back(alpha1); wbe1.push_back(beta1);
    end
    if (done1) begin
      done_cnt1++; done_cyc1 = cyc;
    end
    ns = int'(in_rd1) + int'(core_start1) + int'(out_wr1) + int'(done1);
    strobe_cnt1 += ns;
    if (ns > 1 || (ns > 0 && !busy1)) excl_viol1++;
  end

  // ---------------- L3 instance ----------------
  logic         start3 = 1'b0, busy3, done3, in_rd3, core_start3, out_wr3;
  logic [5:0]   in_addr3, out_addr3;
  logic [W-1:0] r3, eps3, a3, b3, cr3, ce3, ca3, cb3, alpha_in3, beta_in3, alpha3, beta3;
  logic         stub_done3 = 1'b0, pend3 = 1'b0;
  logic [5:0]   pa3;
  logic [W-1:0] sa3, sb3;
  int cnt3 = 0, done_cnt3 = 0, done_cyc3 = 0, excl_viol3 = 0;
  int wa3[$];
  logic [W-1:0] wal3[$];
  logic [W-1:0] wbe3[$];

  plain_broadcast_sched #(.PARAMETER_SET("L3")) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .o_busy(busy3), .o_done(done3),
    .o_in_addr(in_addr3), .o_in_rd(in_rd3), .i_r(r3), .i_eps(eps3), .i_a(a3), .i_b(b3),
    .o_core_start(core_start3), .o_core_r(cr3), .o_core_eps(ce3), .o_core_a(ca3),
    .o_core_b(cb3), .i_core_done(stub_done3), .i_alpha(alpha_in3), .i_beta(beta_in3),
    .o_out_addr(out_addr3), .o_out_wr(out_wr3), .o_alpha(alpha3), .o_beta(beta3));

  always @(negedge clk) begin
    int ns;
    if (pend3) begin
      r3 = mr[pa3]; eps3 = me[pa3]; a3 = ma[pa3]; b3 = mb[pa3];
    end else begin
      r3 = rnd(); eps3 = rnd(); a3 = rnd(); b3 = rnd();
    end
    pend3 = in_rd3;
    pa3 = in_addr3;
    stub_done3 = 1'b0;
    if (cnt3 > 0) begin
      cnt3--;
      if (cnt3 == 0) stub_done3 = 1'b1;
    end
    if (core_start3) begin
      cnt3 = 2; sa3 = cr3 ^ ce3; sb3 = ca3 ^ cb3;
    end
    alpha_in3 = stub_done3 ? sa3 : rnd();
    beta_in3  = stub_done3 ? sb3 : rnd();
    if (out_wr3) begin
      wa3.push_back(int'(out_addr3)); wal3.push_back(alpha3); wbe3.push_back(beta3);
    end
    if (done3) begin
      done_cnt3++; done_cyc3 = cyc;
    end
    ns = int'(in_rd3) + int'(core_start3) + int'(out_wr3) + int'(done3);
    if (ns > 1 || (ns > 0 && !busy3)) excl_viol3++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out1();
    return |{busy1, done1, in_addr1, in_rd1, core_start1, cr1, ce1, ca1, cb1,
             out_addr1, out_wr1, alpha1, beta1};
  endfunction

  task automatic clear_q1();
    wa1.delete(); wc1.delete(); wal1.delete(); wbe1.delete();
  endtask

  // One full L1 run; expected results come from index k: alpha=r^eps, beta=a^b.
  task automatic run_l1(input int lc, input bit spur, input bit restart);
    int d0, scyc, budget, n;
    lc1 = lc;
    spur_en = spur;
    clear_q1();
    d0 = done_cnt1;
    @(negedge clk); start1 = 1'b1; scyc = cyc;
    @(negedge clk); start1 = 1'b0;
    budget = N1 * (4 + lc) + 40;
    for (int i = 0; i < budget && done_cnt1 == d0; i++) begin
      @(negedge clk);
      if (restart) start1 = (i == 30);
    end
    start1 = 1'b0;
    spur_en = 1'b0;
    repeat (5) @(negedge clk);
    chk($sformatf("done_count_lc%0d", lc), done_cnt1 - d0, 1);
    chk($sformatf("done_latency_lc%0d", lc), done_cyc1 - scyc, N1 * (4 + lc) + 1);
    chk($sformatf("busy_after_lc%0d", lc), busy1, 1'b0);
    chk($sformatf("n_writes_lc%0d", lc), wa1.size(), N1);
    n = (wa1.size() < N1) ? wa1.size() : N1;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("addr[%0d]", k), wa1[k], k);
      chk($sformatf("alpha[%0d]", k), wal1[k], mr[k] ^ me[k]);
      chk($sformatf("beta[%0d]", k), wbe1[k], ma[k] ^ mb[k]);
      if (k > 0) chk($sformatf("spacing_lc%0d[%0d]", lc, k), wc1[k] - wc1[k-1], 4 + lc);
    end
    $display("[TB] L1 run lc=%0d spur=%0d restart=%0d: %0d writes, done after %0d cycles",
             lc, spur, restart, wa1.size(), done_cyc1 - scyc);
  endtask

  initial begin
    int s0, scyc3, n;
    for (int k = 0; k < N3; k++) begin
      mr[k] = BASE ^ W'(k);
      me[k] = rnd(); ma[k] = rnd(); mb[k] = rnd();
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_l1", any_out1(), 1'b0);
    chk("reset_busy_l3", busy3, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_strobe", strobe_cnt1, 0);

    run_l1(3, 1'b0, 1'b0);
    run_l1(1, 1'b0, 1'b0);
    run_l1(50, 1'b0, 1'b0);
    run_l1(3, 1'b1, 1'b1);

    // Reset during the wait of repetition 5
    lc1 = 3;
    clear_q1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < 400 && wa1.size() < 5; i++) @(negedge clk);
    for (int i = 0; i < 20 && !core_start1; i++) @(negedge clk);
    chk("reached_start_rep5", core_start1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", any_out1(), 1'b0);
    chk("midrun_reset_busy", busy1, 1'b0);
    chk("writes_before_reset", wa1.size(), 5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = strobe_cnt1;
    repeat (10) @(negedge clk);
    chk("no_strobe_after_reset", strobe_cnt1 - s0, 0);
    $display("[TB] mid-run reset: %0d writes before reset, %0d strobes after release",
             wa1.size(), strobe_cnt1 - s0);
    run_l1(3, 1'b0, 1'b0);

    // L3 parameter set, core latency 2
    @(negedge clk); start3 = 1'b1; scyc3 = cyc;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < N3 * 6 + 40 && done_cnt3 == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("l3_done_count", done_cnt3, 1);
    chk("l3_done_latency", done_cyc3 - scyc3, N3 * 6 + 1);
    chk("l3_n_writes", wa3.size(), N3);
    n = (wa3.size() < N3) ? wa3.size() : N3;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("l3_addr[%0d]", k), wa3[k], k);
      chk($sformatf("l3_alpha[%0d]", k), wal3[k], mr[k] ^ me[k]);
      chk($sformatf("l3_beta[%0d]", k), wbe3[k], ma[k] ^ mb[k]);
    end
    $display("[TB] L3 run: %0d writes, done after %0d cycles", wa3.size(), done_cyc3 - scyc3);

    chk("strobe_exclusive_l1", excl_viol1, 0);
    chk("strobe_exclusive_l3", excl_viol3, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
